// File: rtl/mac_vec_acc_if.sv
// Operand/result bundle for the vector MAC: the source drives pairs and
// clr, the engine returns running state and completed-vector results.
interface mac_vec_acc_if #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 16,
   parameter int LEN    = 4
);
   localparam int CNT_W = $clog2(LEN) + 1;

   logic              clr;
   logic              in_valid;
   logic [DATA_W-1:0] a;
   logic [DATA_W-1:0] b;
   logic [ACC_W-1:0]  acc;
   logic [CNT_W-1:0]  cnt;
   logic              carry;
   logic              done;
   logic [ACC_W-1:0]  result;
   logic              ovf;

   modport master (
      output clr, in_valid, a, b,
      input  acc, cnt, carry, done, result, ovf
   );

   modport slave (
      input  clr, in_valid, a, b,
      output acc, cnt, carry, done, result, ovf
   );
endinterface

// File: rtl/mac_vec_acc.sv
// Two-stage unsigned multiply-accumulate over LEN-pair vectors.
// Define MAC_SATURATE_EN to clamp overflowing vectors to all ones.
module mac_vec_acc #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 16,
   parameter int LEN    = 4
) (
   input logic          clk,
   input logic          reset,
   mac_vec_acc_if.slave bus
);
   localparam int CNT_W = $clog2(LEN) + 1;
   localparam int PW    = 2 * DATA_W;
   localparam int SW    = ACC_W + 1;

   logic [PW-1:0]    r_prod;
   logic             r_p_vld;
   logic [ACC_W-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;
   logic             r_carry;
   logic             r_done;
   logic [ACC_W-1:0] r_result;
   logic             r_ovf;

   logic [PW-1:0]    w_prod;
   logic [SW-1:0]    w_sum;
   logic             w_ovf;
   logic             w_last;
   logic [ACC_W-1:0] w_val;

   assign w_prod = PW'(bus.a) * PW'(bus.b);
   assign w_sum  = {1'b0, r_acc} + SW'(r_prod);
   assign w_ovf  = r_carry | w_sum[ACC_W];
   assign w_last = (r_cnt == CNT_W'(LEN - 1));

`ifdef MAC_SATURATE_EN
   // Once carry is set the vector stays pinned at all ones.
   assign w_val = w_ovf ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
`else
   assign w_val = w_sum[ACC_W-1:0];
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_prod   <= '0;
         r_p_vld  <= 1'b0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_carry  <= 1'b0;
         r_done   <= 1'b0;
         r_result <= '0;
         r_ovf    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (bus.clr) begin
            r_p_vld <= 1'b0;
            r_acc   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
         end else begin
            r_p_vld <= bus.in_valid;
            if (bus.in_valid)
               r_prod <= w_prod;
            if (r_p_vld) begin
               if (w_last) begin
                  r_result <= w_val;
                  r_ovf    <= w_ovf;
                  r_done   <= 1'b1;
                  r_acc    <= '0;
                  r_cnt    <= '0;
                  r_carry  <= 1'b0;
               end else begin
                  r_acc   <= w_val;
                  r_cnt   <= r_cnt + CNT_W'(1);
                  r_carry <= w_ovf;
               end
            end
         end
      end
   end

   assign bus.acc    = r_acc;
   assign bus.cnt    = r_cnt;
   assign bus.carry  = r_carry;
   assign bus.done   = r_done;
   assign bus.result = r_result;
   assign bus.ovf    = r_ovf;
endmodule
